// File: rtl/lift_scheduler.sv
// Lift scheduler: latches floor calls, picks targets with a direction-preserving sweep,
// and sequences the door / ready / move states that drive the travel timer.
module lift_scheduler #(
    parameter int NFLOORS     = 8,
    parameter int FW          = 3,
    parameter int DOOR_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NFLOORS-1:0] call_req,
    input  logic               reached,
    output logic [2:0]         current_state,
    output logic [FW-1:0]      pfloor,
    output logic [FW-1:0]      nfloor,
    output logic [NFLOORS-1:0] call_pending,
    output logic               dir_up,
    output logic               call_served,
    output logic [FW-1:0]      served_floor
);

    localparam logic [2:0] ST_DOOR_OPEN  = 3'd1;
    localparam logic [2:0] ST_DOOR_CLOSE = 3'd2;
    localparam logic [2:0] ST_READY      = 3'd3;
    localparam logic [2:0] ST_MOVE_UP    = 3'd4;
    localparam logic [2:0] ST_MOVE_DOWN  = 3'd5;

    localparam int            CW       = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DOOR_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [FW-1:0]      pfloor_q, pfloor_d;
    logic [FW-1:0]      nfloor_q, nfloor_d;
    logic [NFLOORS-1:0] pending_q, pending_d;
    logic               dir_up_q, dir_up_d;
    logic               served_q, served_d;
    logic [FW-1:0]      served_floor_q, served_floor_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NFLOORS-1:0] above_mask, below_mask, here_mask, nf_mask;
    logic [NFLOORS-1:0] pend_all, above_set, below_set;
    logic [FW-1:0]      up_tgt, dn_tgt;

    // Per-floor position masks relative to the present and target floors.
    generate
        for (genvar gi = 0; gi < NFLOORS; gi++) begin : g_mask
            assign above_mask[gi] = (FW'(gi) > pfloor_q);
            assign below_mask[gi] = (FW'(gi) < pfloor_q);
            assign here_mask[gi]  = (FW'(gi) == pfloor_q);
            assign nf_mask[gi]    = (FW'(gi) == nfloor_q);
        end
    endgenerate

    assign pend_all  = pending_q | call_req;
    assign above_set = pend_all & above_mask;
    assign below_set = pend_all & below_mask;

    // Nearest pending floor in each direction: lowest above, highest below.
    always_comb begin
        up_tgt = '0;
        dn_tgt = '0;
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (above_set[i]) up_tgt = FW'(i);
        end
        for (int i = 0; i < NFLOORS; i++) begin
            if (below_set[i]) dn_tgt = FW'(i);
        end
    end

    always_comb begin
        state_d        = state_q;
        pfloor_d       = pfloor_q;
        nfloor_d       = nfloor_q;
        pending_d      = pend_all;
        dir_up_d       = dir_up_q;
        served_d       = 1'b0;
        served_floor_d = served_floor_q;
        cnt_d          = cnt_q;

        case (state_q)
            ST_READY: begin
                if (|(pend_all & here_mask)) begin
                    pending_d      = pend_all & ~here_mask;
                    served_d       = 1'b1;
                    served_floor_d = pfloor_q;
                    state_d        = ST_DOOR_OPEN;
                    cnt_d          = '0;
                end else if (dir_up_q && |above_set) begin
                    nfloor_d = up_tgt;
                    state_d  = ST_MOVE_UP;
                end else if (|below_set) begin
                    nfloor_d = dn_tgt;
                    dir_up_d = 1'b0;
                    state_d  = ST_MOVE_DOWN;
                end else if (|above_set) begin
                    nfloor_d = up_tgt;
                    dir_up_d = 1'b1;
                    state_d  = ST_MOVE_UP;
                end
            end

            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (reached) begin
                    pfloor_d       = nfloor_q;
                    pending_d      = pend_all & ~nf_mask;
                    served_d       = 1'b1;
                    served_floor_d = nfloor_q;
                    state_d        = ST_DOOR_OPEN;
                    cnt_d          = '0;
                end
            end

            ST_DOOR_OPEN: begin
                // A call at the open floor is absorbed and simply extends the dwell.
                pending_d = pend_all & ~here_mask;
                if (|(call_req & here_mask)) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DOOR_CLOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DOOR_CLOSE: begin
                pending_d = pend_all & ~here_mask;
                if (|(call_req & here_mask)) begin
                    served_d       = 1'b1;
                    served_floor_d = pfloor_q;
                    state_d        = ST_DOOR_OPEN;
                    cnt_d          = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_READY;
            pfloor_q       <= '0;
            nfloor_q       <= '0;
            pending_q      <= '0;
            dir_up_q       <= 1'b1;
            served_q       <= 1'b0;
            served_floor_q <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            pfloor_q       <= pfloor_d;
            nfloor_q       <= nfloor_d;
            pending_q      <= pending_d;
            dir_up_q       <= dir_up_d;
            served_q       <= served_d;
            served_floor_q <= served_floor_d;
            cnt_q          <= cnt_d;
        end
    end

    assign current_state = state_q;
    assign pfloor        = pfloor_q;
    assign nfloor        = nfloor_q;
    assign call_pending  = pending_q;
    assign dir_up        = dir_up_q;
    assign call_served   = served_q;
    assign served_floor  = served_floor_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// Directed bench for lift_scheduler: expected served floors go into a scoreboard
// queue that a negedge monitor drains; state/floor checks run inline with stimulus.
module tb_lift_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] call_req;
    logic       reached;
    logic [2:0] current_state;
    logic [2:0] pfloor;
    logic [2:0] nfloor;
    logic [7:0] call_pending;
    logic       dir_up;
    logic       call_served;
    logic [2:0] served_floor;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    lift_scheduler #(.NFLOORS(8), .FW(3), .DOOR_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_req     (call_req),
        .reached      (reached),
        .current_state(current_state),
        .pfloor       (pfloor),
        .nfloor       (nfloor),
        .call_pending (call_pending),
        .dir_up       (dir_up),
        .call_served  (call_served),
        .served_floor (served_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Scoreboard monitor: every call_served pulse must match the next expected floor.
    always @(negedge clk) begin
        if (rst_n && call_served) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_serve: got floor %0d expected no serve", served_floor);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("served_floor", int'(served_floor), e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic call(input int f);
        call_req = 8'd1 << f;
        step();
        call_req = '0;
    endtask

    task automatic check_move(input int st, input int nf, input int du);
        chk("move_state", int'(current_state), st);
        chk("move_nfloor", int'(nfloor), nf);
        chk("move_dir_up", int'(dir_up), du);
    endtask

    task automatic finish_move(input int nf, input logic [7:0] extra);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nfloor_stable", int'(nfloor), nf);
        end
        exp_q.push_back(nf);
        reached  = 1'b1;
        call_req = extra;
        step();
        reached  = 1'b0;
        call_req = '0;
        chk("arrive_pfloor", int'(pfloor), nf);
        chk("arrive_state", int'(current_state), 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (current_state != 3'd3 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("wait_ready_timeout", int'(current_state), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        call_req = '0;
        reached  = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Asynchronous reset mid-move clears everything without a clock edge.
        call(2);
        chk("pre_reset_state", int'(current_state), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", int'(current_state), 3);
        chk("rst_pfloor", int'(pfloor), 0);
        chk("rst_nfloor", int'(nfloor), 0);
        chk("rst_pending", int'(call_pending), 0);
        chk("rst_dir_up", int'(dir_up), 1);
        chk("rst_served", int'(call_served), 0);
        step();
        rst_n = 1'b1;
        step();

        // Single call to floor 5 with full door sequence.
        call(5);
        check_move(4, 5, 1);
        finish_move(5, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("door_open_phase", int'(current_state), 1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("door_close_phase", int'(current_state), 2);
            step();
        end
        chk("back_ready", int'(current_state), 3);

        // Get to floor 3 heading up: down to 0, then up to 3.
        call(0);
        check_move(5, 0, 0);
        finish_move(0, 8'h00);
        wait_ready();
        call(3);
        check_move(4, 3, 1);
        finish_move(3, 8'h00);
        wait_ready();

        // Sweep order from floor 3 going up with calls at 1, 6, 7.
        call_req = 8'hC2;
        step();
        call_req = '0;
        check_move(4, 6, 1);
        finish_move(6, 8'h00);
        wait_ready();
        step();
        check_move(4, 7, 1);
        finish_move(7, 8'h00);
        wait_ready();
        step();
        check_move(5, 1, 0);
        finish_move(1, 8'h00);
        wait_ready();

        // New call during a move latches but does not retarget.
        call(6);
        check_move(4, 6, 1);
        call_req = 8'h10;
        step();
        call_req = '0;
        chk("no_retarget_nfloor", int'(nfloor), 6);
        chk("latched_pending4", int'(call_pending[4]), 1);
        finish_move(6, 8'h00);
        wait_ready();
        step();
        check_move(5, 4, 0);
        finish_move(4, 8'h00);
        wait_ready();

        // Door edge cases at floor 2.
        call(2);
        check_move(5, 2, 0);
        finish_move(2, 8'h00);
        step();
        step();
        step();
        chk("open_cnt3_state", int'(current_state), 1);
        call(2);
        for (int i = 0; i < 4; i++) begin
            chk("open_extended", int'(current_state), 1);
            step();
        end
        chk("close_after_extend", int'(current_state), 2);
        chk("absorbed_pending2", int'(call_pending[2]), 0);
        exp_q.push_back(2);
        call(2);
        chk("reopen_state", int'(current_state), 1);
        chk("reopen_pending2", int'(call_pending[2]), 0);
        wait_ready();

        // reached is ignored outside the move states.
        reached = 1'b1;
        step();
        reached = 1'b0;
        chk("ready_reached_state", int'(current_state), 3);
        chk("ready_reached_pfloor", int'(pfloor), 2);
        exp_q.push_back(2);
        call(2);
        chk("idle_serve_latency", int'(current_state), 1);
        reached = 1'b1;
        step();
        reached = 1'b0;
        chk("open_reached_state", int'(current_state), 1);
        chk("open_reached_pfloor", int'(pfloor), 2);
        wait_ready();

        // reached together with a call for the target floor: one serve, bit cleared.
        call(5);
        check_move(4, 5, 1);
        finish_move(5, 8'h20);
        chk("simul_pending5", int'(call_pending[5]), 0);
        wait_ready();
        step();
        chk("idle_stays_ready", int'(current_state), 3);

        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lift_scheduler.md
Name: lift_scheduler

Overview:
- Central controller for the lift. Latches floor call requests and picks the next target floor with a direction-preserving sweep policy.
- Sequences the door-open, door-close, ready and move states.
- Drives the lift travel timer with current_state, pfloor and nfloor, and consumes the timer's reached pulse to finish each move.
- Sits between the floor call buttons and the travel timer.

Parameters:
NFLOORS, 8, number of floors served (floors 0..NFLOORS-1), 2..16
FW, 3, floor index width, must be >= clog2(NFLOORS)
DOOR_CYCLES, 4, clock cycles spent in each of DOOR_OPEN and DOOR_CLOSE, >= 1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
call_req  input  NFLOORS  one-hot-per-floor call requests, sampled every cycle, bit i = call at floor i
reached  input  1  travel-complete pulse from timer, honoured only in MOVE_UP/MOVE_DOWN
current_state  output  3  1=DOOR_OPEN 2=DOOR_CLOSE 3=READY 4=MOVE_UP 5=MOVE_DOWN, zero-extended to 32 bits at the timer instance
pfloor  output  FW  present floor
nfloor  output  FW  target floor of the current or most recent move
call_pending  output  NFLOORS  latched unserved calls
dir_up  output  1  sweep direction, 1=up, 0=down
call_served  output  1  one-cycle pulse when a floor is served (door opens)
served_floor  output  FW  floor served, valid while call_served=1, holds last value otherwise

Behaviour:
- Reset (async assert, sync release): current_state=READY(3), pfloor=0, nfloor=0, call_pending=0, dir_up=1, call_served=0, served_floor=0, door counter=0.
- Latching: call_pending |= call_req every cycle, except the bit for the floor being served in that cycle (see the absorb rules). Out-of-range bits do not exist; width is exactly NFLOORS.
- READY, evaluated against pending including this cycle's call_req, with priority in this order:
  1. Bit pfloor set: clear it, pulse call_served with served_floor=pfloor, go to DOOR_OPEN.
  2. dir_up=1 and any bit above pfloor: nfloor = lowest set bit > pfloor, go to MOVE_UP.
  3. Any bit below pfloor: nfloor = highest set bit < pfloor, dir_up=0, go to MOVE_DOWN.
  4. dir_up=0 and any bit above pfloor: nfloor = lowest set bit above, dir_up=1, go to MOVE_UP.
  5. None set: remain in READY, no outputs change.
  - Rule 3 applies only when dir_up=1 has no bits above, or dir_up=0; the symmetric rule holds for down sweeps.
- MOVE_UP/MOVE_DOWN:
  - nfloor and pfloor are held constant for the whole move; the timer depends on stable inputs.
  - New calls latch but never retarget an in-progress move.
  - On reached=1: pfloor<=nfloor, clear pending[nfloor], pulse call_served with served_floor=nfloor, go to DOOR_OPEN, door counter=0.
  - reached in any other state is ignored.
- DOOR_OPEN:
  - Counter increments each cycle; at count DOOR_CYCLES-1, go to DOOR_CLOSE with counter=0. Dwell is exactly DOOR_CYCLES cycles.
  - call_req[pfloor] is absorbed (never set pending), and the counter restarts at 0 with no extra call_served pulse.
- DOOR_CLOSE:
  - Counts DOOR_CYCLES cycles, then goes to READY.
  - call_req[pfloor] here re-opens: go to DOOR_OPEN, counter=0, call_served pulses with served_floor=pfloor, and the bit is not set pending.
- Latency: a call at an idle lift on pfloor gives call_served on the next clock edge. A call elsewhere enters MOVE_* on the next edge.
- Simultaneous events: reached and call_req[nfloor] in the same cycle give one call_served pulse, and the bit ends cleared.
- Reset mid-move or mid-door: immediate return to the reset values. Pending calls are lost.
- No illegal state persists: any unencoded state value goes to READY on the next clock.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle -> outputs immediately read state=3, pfloor=0, pending=0, dir_up=1, without waiting for a clock edge.
- Idle at floor 0, pulse call_req=8'b0010_0000 -> next cycle state=4, nfloor=5. Drive reached after 5 cycles -> pfloor=5, call_served=1, served_floor=5, state=1 for 4 cycles, then 2 for 4 cycles, then 3.
- At floor 3 with dir_up=1, pending bits 1, 6, 7 -> serves 6, 7, then dir_up=0, then 1, in that order. Each move's nfloor is stable until reached.
- During MOVE_UP to 6, raise call_req[4] -> nfloor stays 6 and pending[4]=1. After floor 6 is served, the next move is MOVE_DOWN to 4.
- Door edge cases at pfloor=2:
  - call_req[2] in DOOR_OPEN cycle 3 -> DOOR_OPEN extends 4 more cycles, no second call_served.
  - call_req[2] in DOOR_CLOSE -> returns to state=1 with call_served=1.
- reached pulsed while READY or DOOR_OPEN -> no change to state or pfloor.
